// File: rtl/avalon_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel Avalon-MM interval timer.
package avalon_multi_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_PENDING  = 3'd7
  } reg_e;

  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;

  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period/prescale registers, prescaler, down-counter, RUN/TO flags, snapshot.
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRESC_W      = 16,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_status,
  input  logic        i_wr_control,
  input  logic        i_wr_period_l,
  input  logic        i_wr_period_h,
  input  logic        i_wr_snap,
  input  logic        i_wr_prescale,
  input  logic [15:0] i_wdata,
  output logic [1:0]  o_status,
  output logic [3:0]  o_control,
  output logic [31:0] o_period,
  output logic [31:0] o_snap,
  output logic [15:0] o_prescale,
  output logic        o_irq
);

  localparam bit HasHigh = (CNT_W > 16);

  logic [CNT_W-1:0]   r_cnt, r_period, r_snap;
  logic [PRESC_W-1:0] r_presc, r_presc_cnt;
  logic [3:0]         r_ctl;
  logic               r_run, r_to, r_reload;
  logic               w_tick, w_expire, w_start, w_stop, w_wr_high;
  logic [31:0]        w_period32;

  assign w_start   = i_wr_control & i_wdata[CTL_START];
  assign w_stop    = i_wr_control & i_wdata[CTL_STOP];
  assign w_wr_high = i_wr_period_h & HasHigh;
  assign w_tick    = r_run & (r_presc_cnt == '0);
  // A pending force-reload owns the counter, so a tick in that cycle cannot time out.
  assign w_expire  = w_tick & (r_cnt == '0) & ~r_reload;

  always_comb begin
    w_period32 = 32'(r_period);
    if (i_wr_period_l) w_period32[15:0] = i_wdata;
    if (w_wr_high) w_period32[31:16] = i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= CNT_W'(RESET_PERIOD);
      r_period    <= CNT_W'(RESET_PERIOD);
      r_snap      <= '0;
      r_presc     <= '0;
      r_presc_cnt <= '0;
      r_ctl       <= '0;
      r_run       <= 1'b0;
      r_to        <= 1'b0;
      r_reload    <= 1'b0;
    end else begin
      r_period <= w_period32[CNT_W-1:0];
      r_reload <= i_wr_period_l | w_wr_high;
      if (i_wr_prescale) r_presc <= PRESC_W'(i_wdata);
      if (i_wr_control) r_ctl <= i_wdata[3:0];
      if (i_wr_snap) r_snap <= r_cnt;

      if (r_reload) r_cnt <= r_period;
      else if (w_tick) r_cnt <= (r_cnt == '0) ? r_period : r_cnt - CNT_W'(1);

      if (w_start) r_run <= 1'b1;
      else if (w_stop || r_reload) r_run <= 1'b0;
      else if (w_expire) r_run <= r_ctl[CTL_CONT];

      if (w_start || r_reload) r_presc_cnt <= r_presc;
      else if (r_run) r_presc_cnt <= (r_presc_cnt == '0) ? r_presc : r_presc_cnt - PRESC_W'(1);

      // Timeout beats a simultaneous clear so no event is lost.
      if (w_expire) r_to <= 1'b1;
      else if (i_wr_status) r_to <= 1'b0;
    end
  end

  assign o_status   = {r_run, r_to};
  assign o_control  = r_ctl;
  assign o_period   = 32'(r_period);
  assign o_snap     = 32'(r_snap);
  assign o_prescale = 16'(r_presc);
  assign o_irq      = r_to & r_ctl[CTL_ITO];

endmodule

// File: rtl/avalon_multi_timer.sv
// NUM_CH interval timers behind one 16-bit Avalon-MM slave with an OR-reduced interrupt.
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRESC_W      = 16,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(NUM_CH)+2:0]    address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [15:0]                  writedata,
  output logic [15:0]                  readdata,
  output logic                         irq
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [ChW-1:0]               w_ch;
  reg_e                         w_reg;
  logic                         w_wr;
  logic [NUM_CH-1:0]            w_pending;
  logic [NUM_CH-1:0][15:0]      w_rd_ch;
  logic [15:0]                  w_rd_next;
  logic [15:0]                  r_readdata;

  if (NUM_CH > 1) begin : g_ch_idx
    assign w_ch = address[$clog2(NUM_CH)+2:3];
  end else begin : g_ch_single
    assign w_ch = '0;
  end

  assign w_reg = reg_e'(address[2:0]);
  assign w_wr  = chipselect & ~write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic        w_sel, w_irq;
    logic [1:0]  w_status;
    logic [3:0]  w_control;
    logic [31:0] w_period, w_snap;
    logic [15:0] w_prescale, w_rd;

    assign w_sel = w_wr & (w_ch == ChW'(i));

    timer_channel #(
      .CNT_W       (CNT_W),
      .PRESC_W     (PRESC_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .i_clk        (clk),
      .i_rst_n      (reset_n),
      .i_wr_status  (w_sel & (w_reg == REG_STATUS)),
      .i_wr_control (w_sel & (w_reg == REG_CONTROL)),
      .i_wr_period_l(w_sel & (w_reg == REG_PERIOD_L)),
      .i_wr_period_h(w_sel & (w_reg == REG_PERIOD_H)),
      .i_wr_snap    (w_sel & ((w_reg == REG_SNAP_L) | (w_reg == REG_SNAP_H))),
      .i_wr_prescale(w_sel & (w_reg == REG_PRESCALE)),
      .i_wdata      (writedata),
      .o_status     (w_status),
      .o_control    (w_control),
      .o_period     (w_period),
      .o_snap       (w_snap),
      .o_prescale   (w_prescale),
      .o_irq        (w_irq)
    );

    always_comb begin
      w_rd = '0;
      unique case (w_reg)
        REG_STATUS:   w_rd = {14'b0, w_status};
        REG_CONTROL:  w_rd = {12'b0, w_control};
        REG_PERIOD_L: w_rd = w_period[15:0];
        REG_PERIOD_H: w_rd = w_period[31:16];
        REG_SNAP_L:   w_rd = w_snap[15:0];
        REG_SNAP_H:   w_rd = w_snap[31:16];
        REG_PRESCALE: w_rd = w_prescale;
        REG_PENDING:  w_rd = 16'(w_pending);
        default:      w_rd = '0;
      endcase
    end

    assign w_rd_ch[i]   = w_rd;
    assign w_pending[i] = w_irq;
  end

  // Channel slots at or beyond NUM_CH match no channel and read as zero.
  always_comb begin
    w_rd_next = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_ch == ChW'(k)) w_rd_next = w_rd_ch[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_next;
  end

  assign readdata = r_readdata;
  assign irq      = |w_pending;

endmodule
